// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared constants and helpers for the round-robin one-hot arbiter and its
// downstream one-hot-to-index stage.
package rr_onehot_arbiter_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_PTR_W    = 3;
    localparam int ARB_ONEHOT_W = ARB_N;

    localparam logic [ARB_ONEHOT_W-1:0] GRANT_NONE = 8'd0;

    // OR-encoder: exact index for any legal one-hot value, 0 for all-zero.
    function automatic logic [ARB_PTR_W-1:0] onehot_to_idx(input logic [ARB_ONEHOT_W-1:0] oh);
        logic [ARB_PTR_W-1:0] r;
        r = 3'd0;
        for (int i = 0; i < ARB_N; i++) begin
            r = r | ({ARB_PTR_W{oh[i]}} & 3'(i));
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_chk.sv
// Invariant checker for the arbiter outputs: grant is zero or one-hot and
// grant_valid tracks a non-zero grant.
module rr_onehot_arbiter_chk (
    input logic       clk,
    input logic       rst_n,
    input logic [7:0] grant,
    input logic       grant_valid
);

    a_grant_legal: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant) && (grant_valid == (grant != 8'd0)));

endmodule

// File: rtl/rr_onehot_arbiter_pick8.sv
// Combinational rotate-priority select: the first set bit of req at or above
// start, wrapping 7->0.
module rr_pick8
    import rr_onehot_arbiter_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] start,
    output logic [7:0] onehot,
    output logic [2:0] idx,
    output logic       any
);

    logic [15:0] rot_wide_s;
    logic [7:0]  rot_s;
    logic [7:0]  iso_s;
    logic [15:0] back_wide_s;

    // Rotate so start sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot_wide_s  = {req, req} >> start;
        rot_s       = rot_wide_s[7:0];
        iso_s       = rot_s & (~rot_s + 8'd1);
        back_wide_s = {iso_s, iso_s} << start;
        onehot      = back_wide_s[15:8];
        idx         = onehot_to_idx(onehot);
        any         = |req;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Registered round-robin arbiter over 8 requesters with a valid/ready grant
// handshake; the pointer advances only when a grant is accepted.
module rr_onehot_arbiter
    import rr_onehot_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] grant,
    output logic       grant_valid,
    input  logic       grant_ready,
    output logic       busy
);

    logic [ARB_ONEHOT_W-1:0] grant_r;
    logic                    grant_valid_r;
    logic [ARB_PTR_W-1:0]    ptr_r;

    logic                    accept_s;
    logic                    slot_free_s;
    logic [ARB_PTR_W-1:0]    cur_idx_s;
    logic [ARB_PTR_W-1:0]    next_ptr_s;
    logic [ARB_PTR_W-1:0]    start_s;
    logic [ARB_ONEHOT_W-1:0] pick_onehot_s;
    logic [ARB_PTR_W-1:0]    pick_idx_s;
    logic                    pick_any_s;

    // Handshake decode; on a back-to-back edge the search starts past the
    // grant being accepted rather than from the stale pointer.
    always_comb begin
        accept_s    = grant_valid_r & grant_ready;
        slot_free_s = ~grant_valid_r | accept_s;
        cur_idx_s   = onehot_to_idx(grant_r);
        next_ptr_s  = cur_idx_s + 3'd1;
        if (accept_s) begin
            start_s = next_ptr_s;
        end else begin
            start_s = ptr_r;
        end
    end

    rr_pick8 u_pick (
        .req    (req),
        .start  (start_s),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Grant register: arbitrate into a free slot, otherwise hold the committed winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r       <= GRANT_NONE;
            grant_valid_r <= 1'b0;
        end else if (slot_free_s) begin
            if (pick_any_s) begin
                grant_r       <= pick_onehot_s;
                grant_valid_r <= 1'b1;
            end else begin
                grant_r       <= GRANT_NONE;
                grant_valid_r <= 1'b0;
            end
        end else begin
            grant_r       <= grant_r;
            grant_valid_r <= grant_valid_r;
        end
    end

    // Fairness pointer moves only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= 3'd0;
        end else if (accept_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign busy        = grant_valid_r & ~grant_ready;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed-vector bench for rr_onehot_arbiter plus a reference-model soak.
module tb_rr_onehot_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'd0;
    logic       grant_ready = 1'b0;
    logic [7:0] grant;
    logic       grant_valid;
    logic       busy;

    int n_vec = 0;
    int n_miscmp = 0;

    // reference model state
    logic [7:0] m_grant;
    logic       m_valid;
    logic [2:0] m_ptr;
    int         wait_acc [8];
    logic       starved;

    always #5 clk = ~clk;

    rr_onehot_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .busy        (busy)
    );

    rr_onehot_arbiter_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 8'd0;
        grant_ready = 1'b0;
        m_grant = 8'd0;
        m_valid = 1'b0;
        m_ptr = 3'd0;
        for (int i = 0; i < 8; i++) wait_acc[i] = 0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [2:0] conv_idx(input logic [7:0] oh);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
        return r;
    endfunction

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_step();
        logic       acc;
        logic [2:0] start;
        logic [2:0] gi;
        logic       found;
        logic [2:0] k;
        acc = m_valid & grant_ready;
        gi = conv_idx(m_grant);
        start = m_ptr;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (!req[i] || gi == 3'(i)) wait_acc[i] = 0;
                else wait_acc[i] = wait_acc[i] + 1;
                if (wait_acc[i] >= 8) starved = 1'b1;
            end
            m_ptr = gi + 3'd1;
            start = m_ptr;
        end else begin
            for (int i = 0; i < 8; i++) if (!req[i]) wait_acc[i] = 0;
        end
        if (!m_valid || acc) begin
            found = 1'b0;
            m_grant = 8'd0;
            for (int j = 0; j < 8; j++) begin
                k = start + 3'(j);
                if (!found && req[k]) begin
                    found = 1'b1;
                    m_grant[k] = 1'b1;
                end
            end
            m_valid = found;
        end
    endtask

    initial begin
        logic [7:0] one;
        one = 8'h01;
        starved = 1'b0;

        // reset state
        do_reset();
        check_val("rst_grant", grant, 8'h00);
        check_val("rst_valid", grant_valid, 1'b0);
        check_val("rst_busy", busy, 1'b0);

        // build a pending 0x10 grant, then reset asynchronously mid-cycle
        req = 8'h10;
        tick();
        check_val("pre_rst_grant", grant, 8'h10);
        check_val("pre_rst_valid", grant_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_grant", grant, 8'h00);
        check_val("async_rst_valid", grant_valid, 1'b0);
        tick();
        rst_n = 1'b1;

        // full contention from ptr 0
        req = 8'hFF;
        grant_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_val($sformatf("contend%0d", k), grant, one << (k % 8));
        end

        // stall hold, req changes ignored while stalled
        do_reset();
        req = 8'h24;
        tick();
        check_val("stall_first", grant, 8'h04);
        for (int k = 0; k < 4; k++) begin
            if (k >= 2) req = 8'h01;
            tick();
            check_val($sformatf("stall_grant%0d", k), grant, 8'h04);
            check_val($sformatf("stall_busy%0d", k), busy, 1'b1);
        end
        req = 8'h24;
        grant_ready = 1'b1;
        #1;
        check_val("stall_busy_rel", busy, 1'b0);
        tick();
        check_val("stall_next", grant, 8'h20);

        // wrap and skip: accept of requester 6 puts ptr at 7
        do_reset();
        req = 8'h40;
        grant_ready = 1'b1;
        tick();
        check_val("wrap_g6", grant, 8'h40);
        req = 8'h81;
        tick();
        check_val("wrap_g7", grant, 8'h80);
        tick();
        check_val("wrap_g0", grant, 8'h01);

        // single requester, then drop while stalled
        do_reset();
        req = 8'h08;
        grant_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("single%0d", k), grant, 8'h08);
        end
        req = 8'h00;
        grant_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_val($sformatf("drop_hold%0d", k), grant, 8'h08);
            check_val($sformatf("drop_valid%0d", k), grant_valid, 1'b1);
        end
        grant_ready = 1'b1;
        tick();
        check_val("drop_grant", grant, 8'h00);
        check_val("drop_valid", grant_valid, 1'b0);

        // random soak against the reference model
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            req = 8'($urandom);
            if ($urandom_range(0, 7) == 0) req = 8'hFF;
            grant_ready = ($urandom_range(0, 3) != 0);
            model_step();
            tick();
            check_val("soak_grant", grant, m_grant);
            check_val("soak_valid", grant_valid, m_valid);
            if (m_valid) check_val("soak_idx", conv_idx(grant), conv_idx(m_grant));
        end
        check_val("soak_starve", starved, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
